// File: rtl/qubit_grid_pkg.sv
// rtl/qubit_grid_pkg.sv - shared constants and LFSR step for the qubit grid engine
package qubit_grid_pkg;

   // Register indices (addr[3:2])
   localparam logic [1:0] REG_ERRORS   = 2'd0;
   localparam logic [1:0] REG_SYNDROME = 2'd1;
   localparam logic [1:0] REG_NOISE    = 2'd2;
   localparam logic [1:0] REG_CMD      = 2'd3;

   // Command bit positions in a CMD write
   localparam int CMD_STEP    = 0;
   localparam int CMD_MEASURE = 1;
   localparam int CMD_CLEAR   = 2;

   // Noise LFSR
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Grid geometry: data qubits per side, plaquettes per side
   localparam int GRID_N = 4;
   localparam int PLAQ_N = 3;

   // Noise round FSM states
   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_RUN  = 1'b1;

   // One Galois step: shift right, fold the mask in when bit0 falls out
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

endpackage

// File: rtl/qubit_grid_syndrome.sv
// rtl/qubit_grid_syndrome.sv - combinational plaquette parity of the 4x4 error vector
module qubit_grid_syndrome
   import qubit_grid_pkg::*;
(
   input  logic [15:0] err,
   output logic [8:0]  syn
);

   // Each plaquette is the XOR of the four qubits at its corners
   for (genvar r = 0; r < PLAQ_N; r++) begin : g_row
      for (genvar c = 0; c < PLAQ_N; c++) begin : g_col
         assign syn[PLAQ_N*r + c] = err[GRID_N*r + c]     ^ err[GRID_N*r + c + 1] ^
                                    err[GRID_N*r + c + 4] ^ err[GRID_N*r + c + 5];
      end
   end

endmodule

// File: rtl/qubit_grid.sv
// rtl/qubit_grid.sv - memory-mapped X-error grid with noise rounds and syndrome latch
module qubit_grid
   import qubit_grid_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cs,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   logic        state;
   logic [3:0]  q;
   logic [15:0] err;
   logic [15:0] err_next;
   logic [8:0]  syn;
   logic [8:0]  syn_latch;
   logic [8:0]  p;
   logic [15:0] lfsr;
   logic [15:0] lfsr_adv;
   logic [15:0] round;
   logic [1:0]  idx;
   logic        busy;
   logic        wr, err_wr, noise_wr, cmd_wr;
   logic        step_go, clear_go, measure_go, seed_wr, flip;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^addr[1:0];

   assign idx      = addr[3:2];
   assign wr       = cs && we;
   assign err_wr   = wr && (idx == REG_ERRORS);
   assign noise_wr = wr && (idx == REG_NOISE);
   assign cmd_wr   = wr && (idx == REG_CMD);
   assign busy     = (state == STATE_RUN);

   // STEP and CLEAR only act when idle; CLEAR wins over STEP in the same write
   assign step_go    = cmd_wr && wdata[CMD_STEP] && !wdata[CMD_CLEAR] && !busy;
   assign clear_go   = cmd_wr && wdata[CMD_CLEAR] && !busy;
   assign measure_go = cmd_wr && wdata[CMD_MEASURE];
   assign seed_wr    = noise_wr && (wdata[31:16] != 16'h0000);

   // Flip decision uses the freshly advanced value; P >= 256 always flips
   assign lfsr_adv = lfsr_step(lfsr);
   assign flip     = busy && ({1'b0, lfsr_adv[7:0]} < p);

   qubit_grid_syndrome u_syndrome (
      .err (err),
      .syn (syn)
   );

   // Host XOR and noise flip combine in one cycle; CLEAR can only occur when idle
   always_comb begin
      err_next = err;
      if (err_wr) begin
         err_next = err_next ^ wdata[15:0];
      end
      if (flip) begin
         err_next = err_next ^ (16'h0001 << q);
      end
      if (clear_go) begin
         err_next = 16'h0000;
      end
   end

   // Error vector register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 16'h0000;
      end else begin
         err <= err_next;
      end
   end

   // Noise probability and LFSR; a seed write overrides the round's advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p    <= 9'd0;
         lfsr <= LFSR_SEED;
      end else begin
         if (noise_wr) begin
            p <= wdata[8:0];
         end
         if (seed_wr) begin
            lfsr <= wdata[31:16];
         end else if (busy) begin
            lfsr <= lfsr_adv;
         end
      end
   end

   // MEASURE samples the syndrome of the pre-write error vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syn_latch <= 9'd0;
         round     <= 16'h0000;
      end else if (measure_go) begin
         syn_latch <= syn;
         round     <= round + 16'h0001;
      end
   end

   // Noise round: 16 RUN cycles, one qubit per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= STATE_IDLE;
         q     <= 4'd0;
      end else if (state == STATE_IDLE) begin
         if (step_go) begin
            state <= STATE_RUN;
            q     <= 4'd0;
         end
      end else begin
         q <= q + 4'd1;
         if (q == 4'd15) begin
            state <= STATE_IDLE;
         end
      end
   end

   // Combinational read mux, zero unless a read is in progress
   always_comb begin
      rdata = 32'h0000_0000;
      if (cs && !we) begin
         case (idx)
            REG_ERRORS:   rdata = {16'h0000, err};
            REG_SYNDROME: rdata = {23'd0, syn_latch};
            REG_NOISE:    rdata = {lfsr, 7'd0, p};
            REG_CMD:      rdata = {14'd0, busy, (syn_latch != 9'd0), round};
            default:      rdata = 32'h0000_0000;
         endcase
      end
   end

endmodule

// File: tb/tb_qubit_grid.sv
// tb/tb_qubit_grid.sv - directed self-checking bench for qubit_grid
module tb_qubit_grid;

   logic        clk;
   logic        rst_n;
   logic        cs;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] rd;
   int          n_checks;
   int          n_errors;

   qubit_grid dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (cs),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_reg(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      cs    = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      cs    = 1'b0;
      we    = 1'b0;
      wdata = 32'h0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      cs   = 1'b1;
      we   = 1'b0;
      addr = a;
      #1;
      d  = rdata;
      cs = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      cs    = 1'b0;
      we    = 1'b0;
      addr  = 4'h0;
      wdata = 32'h0;
      #12;
      rst_n = 1'b1;
      tick();

      // Reset values
      bus_read(4'h0, rd); check_reg("rst_errors", rd, 32'h0000_0000);
      bus_read(4'h4, rd); check_reg("rst_syndrome", rd, 32'h0000_0000);
      bus_read(4'h8, rd); check_reg("rst_noise", rd, 32'hACE1_0000);
      bus_read(4'hC, rd); check_reg("rst_status", rd, 32'h0000_0000);

      // Single error on qubit 0, measure
      bus_write(4'h0, 32'h0000_0001);
      bus_write(4'hC, 32'h0000_0002);
      bus_read(4'h4, rd); check_reg("q0_syndrome", rd, 32'h0000_0001);
      bus_read(4'hC, rd); check_reg("q0_status", rd, 32'h0001_0001);

      // Only qubit 5 flipped touches plaquettes 0,1,3,4
      bus_write(4'h0, 32'h0000_0021);
      bus_read(4'h0, rd); check_reg("q5_errors", rd, 32'h0000_0020);
      bus_write(4'hC, 32'h0000_0002);
      bus_read(4'h4, rd); check_reg("q5_syndrome", rd, 32'h0000_001B);
      bus_read(4'hC, rd); check_reg("q5_status", rd, 32'h0001_0002);

      // P = 0: 16 busy cycles, no flips, LFSR advanced 16 steps
      bus_write(4'h8, 32'h0000_0000);
      bus_write(4'hC, 32'h0000_0001);
      bus_read(4'hC, rd); check_reg("p0_busy_start", rd, 32'h0003_0002);
      for (int i = 1; i < 16; i++) begin
         tick();
         bus_read(4'hC, rd);
         check_reg("p0_busy_run", {31'd0, rd[17]}, 32'd1);
      end
      tick();
      bus_read(4'hC, rd); check_reg("p0_busy_end", rd, 32'h0001_0002);
      bus_read(4'h0, rd); check_reg("p0_errors", rd, 32'h0000_0020);
      bus_read(4'h8, rd); check_reg("p0_lfsr16", rd, 32'hEB62_0000);

      // P = 256 flips every qubit; a STEP mid-round is ignored
      bus_write(4'hC, 32'h0000_0004);
      bus_read(4'h0, rd); check_reg("clear_errors", rd, 32'h0000_0000);
      bus_write(4'h0, 32'h0000_00F0);
      bus_write(4'h8, 32'h0000_0100);
      bus_write(4'hC, 32'h0000_0001);
      repeat (5) tick();
      bus_write(4'hC, 32'h0000_0001);
      repeat (10) tick();
      bus_read(4'hC, rd); check_reg("pall_status", rd, 32'h0001_0002);
      bus_read(4'h0, rd); check_reg("pall_errors", rd, 32'h0000_FF0F);
      bus_read(4'h8, rd); check_reg("pall_p", rd & 32'h0000_FFFF, 32'h0000_0100);

      // STEP|MEASURE|CLEAR together: measure old ERR, clear, no round
      bus_write(4'h0, 32'h0000_FF0E);
      bus_read(4'h0, rd); check_reg("cmd7_pre_errors", rd, 32'h0000_0001);
      bus_write(4'hC, 32'h0000_0007);
      bus_read(4'h4, rd); check_reg("cmd7_syndrome", rd, 32'h0000_0001);
      bus_read(4'h0, rd); check_reg("cmd7_errors", rd, 32'h0000_0000);
      bus_read(4'hC, rd); check_reg("cmd7_status", rd, 32'h0001_0003);
      tick();
      bus_read(4'hC, rd); check_reg("cmd7_still_idle", rd, 32'h0001_0003);

      // Seed load, addr[1:0] ignored; zero seed keeps the LFSR
      bus_write(4'hB, 32'h1234_0005);
      bus_read(4'h8, rd); check_reg("seed_load", rd, 32'h1234_0005);
      bus_write(4'h9, 32'h0000_0007);
      bus_read(4'hA, rd); check_reg("seed_keep", rd, 32'h1234_0007);

      // SYNDROME is read-only; rdata is zero during writes and without cs
      cs = 1'b1; we = 1'b1; addr = 4'h4; wdata = 32'hFFFF_FFFF;
      #1;
      check_reg("rdata_on_write", rdata, 32'h0000_0000);
      @(posedge clk); #1;
      cs = 1'b0; we = 1'b0; wdata = 32'h0;
      bus_read(4'h4, rd); check_reg("syndrome_ro", rd, 32'h0000_0001);
      addr = 4'h8;
      #1;
      check_reg("rdata_no_cs", rdata, 32'h0000_0000);

      // Reset mid-round aborts everything
      bus_write(4'hC, 32'h0000_0001);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      bus_read(4'hC, rd); check_reg("rst_mid_status", rd, 32'h0000_0000);
      rst_n = 1'b1;
      tick();
      bus_read(4'h0, rd); check_reg("rst2_errors", rd, 32'h0000_0000);
      bus_read(4'h4, rd); check_reg("rst2_syndrome", rd, 32'h0000_0000);
      bus_read(4'h8, rd); check_reg("rst2_noise", rd, 32'hACE1_0000);
      bus_read(4'hC, rd); check_reg("rst2_status", rd, 32'h0000_0000);
      tick();
      bus_read(4'hC, rd); check_reg("rst2_idle", rd, 32'h0000_0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/qubit_grid.md
# qubit_grid

Memory-mapped physics engine that models X-type errors on a 4×4 grid of data qubits and their 3×3 plaquette parity syndrome. It sits on the SoC system bus at base 0x4000_0000 and receives the low address nibble, chip select, write enable and 32-bit data. Software injects errors, runs pseudo-random noise rounds, latches syndromes and reads results back through four word registers.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cs  in  1  transaction valid
- we  in  1  1 = write, 0 = read
- addr  in  4  byte offset; register index = addr[3:2]; addr[1:0] ignored
- wdata  in  32  write data
- rdata  out  32  read data; combinational

## Operation
- Data qubit i = 4·row + col, with row and col in 0..3. The error vector is ERR[15:0], where 1 means the qubit is flipped.
- Plaquette k = 3·r + c, with r and c in 0..2. SYN_k = ERR[4r+c] ^ ERR[4r+c+1] ^ ERR[4r+c+4] ^ ERR[4r+c+5].
- Register map:
  - 0x0 ERRORS (RW).
    - Write: ERR ^= wdata[15:0].
    - Read: {16'b0, ERR}.
  - 0x4 SYNDROME (RO): {23'b0, SYN_LATCH[8:0]}. Writes are ignored.
  - 0x8 NOISE (RW).
    - Write: P[8:0] = wdata[8:0]. If wdata[31:16] ≠ 0, LFSR = wdata[31:16].
    - Read: {LFSR, 7'b0, P}.
  - 0xC CMD/STATUS.
    - Write bit0 STEP: start a noise round.
    - Write bit1 MEASURE: SYN_LATCH ← SYN(ERR current), ROUND ← ROUND+1.
    - Write bit2 CLEAR: ERR ← 0.
    - Read: {14'b0, BUSY, SYN_LATCH≠0, ROUND[15:0]}.
- LFSR: 16-bit Galois, mask 0xB400, shift right, feedback from bit0. It never holds 0.
- Noise round FSM, states IDLE and RUN:
  - STEP in IDLE: go to RUN with qubit index q = 0.
  - Each RUN cycle: advance LFSR one step. Flip ERR[q] if new_lfsr[7:0] < P; P ≥ 256 always flips and P = 0 never flips. Then increment q.
  - After q = 15: return to IDLE. A round is exactly 16 cycles.
- Command priority within one write: MEASURE uses pre-write ERR. CLEAR beats STEP, so the round is not started.
- Commands written while BUSY: STEP and CLEAR are ignored; MEASURE executes.
- ERRORS written while BUSY: the host XOR and the noise flip combine by XOR in the same cycle.
- NOISE written while BUSY: P takes effect from the next cycle. A seed write overrides that cycle's LFSR advance.
- ROUND wraps 0xFFFF → 0x0000.
- rdata = 0 when cs = 0 or we = 1.

## Timing
- Writes commit on the posedge where cs && we.
- Reads are combinational in the same cycle, reflecting register state before that edge.
- Reset values:
  - ERR = 0, SYN_LATCH = 0, P = 0, LFSR = 0xACE1, ROUND = 0, state IDLE, q = 0.
  - rdata = 0 while idle.
- STEP write at edge N: BUSY reads 1 after edge N. Flips occur at edges N+1 … N+16. BUSY reads 0 after edge N+16.
- MEASURE: SYN_LATCH and ROUND are valid after the write edge.
- Asserting rst_n low mid-round aborts it immediately, and all state returns to reset values.

## Structure
- Shared package `qubit_grid_pkg`:
  - register offsets,
  - CMD bit positions,
  - LFSR mask and default seed,
  - grid dimensions (4, 3).
- Sub-module `qubit_grid_syndrome`: purely combinational ERR[15:0] → SYN[8:0].
- The LFSR, FSM and bus decode stay in the top of `qubit_grid`.

## Test plan
- Reset check: read 0x0, 0x4, 0x8, 0xC → 0, 0, 0xACE1_0000, 0.
- Write 0x0 = 0x0001, then 0xC = 0x2 → SYNDROME 0x001, STATUS 0x0001_0001.
- Write 0x0 ^= 0x0021, leaving only qubit 5, then MEASURE → SYNDROME 0x01B, ROUND 2.
- NOISE = 0, STEP → BUSY reads 1 for 16 cycles, ERR unchanged, LFSR advanced 16 steps.
- NOISE = 0x100, ERR = 0x00F0, STEP, wait 16 cycles → ERR = 0xFF0F. A second STEP issued mid-round is ignored.
- Write 0xC = 0x7 with ERR = 0x0001 → SYNDROME 0x001, ERR = 0, BUSY = 0. Pulse rst_n mid-round → all reset values.
